dmi_arbiter: RTL and testbench

//  Shares the single DMI slave port of the debug module (dm::dmi_req_t / dm::dmi_resp_t) between

---
 rtl/dmi_arbiter.sv | 121 ++++++++++++
 tb/tb_dmi_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmi_arbiter.sv
// Round-robin arbiter sharing the debug module's single DMI port between NrPorts masters.
// One transaction in flight; the response is routed back to the master that issued it.
`timescale 1ns/1ps
module dmi_arbiter #(
  parameter int unsigned NrPorts = 2,
  localparam int unsigned IdxWidth = (NrPorts > 1) ? $clog2(NrPorts) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NrPorts-1:0][40:0]  req_i,
  input  logic [NrPorts-1:0]        req_valid_i,
  output logic [NrPorts-1:0]        req_ready_o,
  output logic [NrPorts-1:0][33:0]  resp_o,
  output logic [NrPorts-1:0]        resp_valid_o,
  input  logic [NrPorts-1:0]        resp_ready_i,
  output logic [40:0]               dmi_req_o,
  output logic                      dmi_req_valid_o,
  input  logic                      dmi_req_ready_i,
  input  logic [33:0]               dmi_resp_i,
  input  logic                      dmi_resp_valid_i,
  output logic                      dmi_resp_ready_o,
  output logic                      busy_o,
  output logic [IdxWidth-1:0]       owner_o
);

  // state | meaning
  // Idle  | nothing in flight; arbitrate among valid masters (one cycle)
  // Req   | owner's request forwarded to the DM, waiting for dmi_req_ready_i
  // Resp  | DM response routed to owner, waiting for owner's resp_ready_i
  typedef enum logic [1:0] {Idle, Req, Resp} state_e;

  state_e              state_q, state_d;
  logic [IdxWidth-1:0] owner_q, owner_d;
  logic [IdxWidth-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxWidth-1:0] winner;
  logic [IdxWidth-1:0] cand;
  logic [IdxWidth:0]   sum;
  logic                found;
  logic [IdxWidth-1:0] owner_inc;

  // Search rr_ptr, rr_ptr+1, ... modulo NrPorts; one subtraction suffices since both terms < NrPorts.
  always_comb begin
    winner = rr_ptr_q;
    found  = 1'b0;
    sum    = '0;
    cand   = '0;
    for (int unsigned i = 0; i < NrPorts; i++) begin
      sum = {1'b0, rr_ptr_q} + (IdxWidth+1)'(i);
      if (sum >= (IdxWidth+1)'(NrPorts)) begin
        sum = sum - (IdxWidth+1)'(NrPorts);
      end
      cand = sum[IdxWidth-1:0];
      if (!found && req_valid_i[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign owner_inc = (owner_q == IdxWidth'(NrPorts - 1)) ? '0 : owner_q + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= Idle;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    rr_ptr_d         = rr_ptr_q;
    req_ready_o      = '0;
    resp_o           = '0;
    resp_valid_o     = '0;
    dmi_req_o        = '0;
    dmi_req_valid_o  = 1'b0;
    dmi_resp_ready_o = 1'b0;
    case (state_q)
      Idle: begin
        if (|req_valid_i) begin
          owner_d = winner;
          state_d = Req;
        end
      end
      Req: begin
        dmi_req_o            = req_i[owner_q];
        dmi_req_valid_o      = 1'b1;
        req_ready_o[owner_q] = dmi_req_ready_i;
        if (dmi_req_ready_i) begin
          state_d = Resp;
        end
      end
      Resp: begin
        resp_o[owner_q]       = dmi_resp_i;
        resp_valid_o[owner_q] = dmi_resp_valid_i;
        dmi_resp_ready_o      = resp_ready_i[owner_q];
        if (dmi_resp_valid_i && resp_ready_i[owner_q]) begin
          rr_ptr_d = owner_inc;
          state_d  = Idle;
        end
      end
      default: state_d = Idle;
    endcase
  end

  assign busy_o  = (state_q != Idle);
  assign owner_o = owner_q;

  // Owner must hold its request until accepted; DM must not answer outside Resp.
  a_req_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == Req) |-> req_valid_i[owner_q]);
  a_no_stray_resp: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q != Resp) |-> !dmi_resp_valid_i);

endmodule

// File: tb/tb_dmi_arbiter.sv
// Scoreboard bench for dmi_arbiter: a 2-port and a 3-port instance, each behind a small DM model.
`timescale 1ns/1ps
module tb_dmi_arbiter;

  localparam logic [1:0] OP_NOP = 2'd0;
  localparam logic [1:0] OP_RD  = 2'd1;
  localparam logic [1:0] OP_WR  = 2'd2;

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  // Masters 0,1 -> instance A ports 0,1; masters 2,3,4 -> instance B ports 0,1,2.
  logic [4:0][40:0] m_req;
  logic [4:0]       m_valid;
  logic [4:0]       m_ready;
  logic [4:0][33:0] m_resp;
  logic [4:0]       m_resp_valid;
  logic [4:0]       m_resp_ready;
  logic             a_busy, b_busy;
  logic [0:0]       a_owner;
  logic [1:0]       b_owner;

  logic [40:0] d_req        [2];
  logic        d_req_valid  [2];
  logic        d_req_ready  [2];
  logic [33:0] d_resp       [2];
  logic        d_resp_valid [2];
  logic        d_resp_ready [2];

  dmi_arbiter #(.NrPorts(2)) u_dut_a (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_i(m_req[1:0]), .req_valid_i(m_valid[1:0]), .req_ready_o(m_ready[1:0]),
    .resp_o(m_resp[1:0]), .resp_valid_o(m_resp_valid[1:0]), .resp_ready_i(m_resp_ready[1:0]),
    .dmi_req_o(d_req[0]), .dmi_req_valid_o(d_req_valid[0]), .dmi_req_ready_i(d_req_ready[0]),
    .dmi_resp_i(d_resp[0]), .dmi_resp_valid_i(d_resp_valid[0]), .dmi_resp_ready_o(d_resp_ready[0]),
    .busy_o(a_busy), .owner_o(a_owner)
  );

  dmi_arbiter #(.NrPorts(3)) u_dut_b (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_i(m_req[4:2]), .req_valid_i(m_valid[4:2]), .req_ready_o(m_ready[4:2]),
    .resp_o(m_resp[4:2]), .resp_valid_o(m_resp_valid[4:2]), .resp_ready_i(m_resp_ready[4:2]),
    .dmi_req_o(d_req[1]), .dmi_req_valid_o(d_req_valid[1]), .dmi_req_ready_i(d_req_ready[1]),
    .dmi_resp_i(d_resp[1]), .dmi_resp_valid_i(d_resp_valid[1]), .dmi_resp_ready_o(d_resp_ready[1]),
    .busy_o(b_busy), .owner_o(b_owner)
  );

  // DM model: reads return a fixed pattern, write to 0x7F fails, everything else succeeds.
  function automatic logic [33:0] dm_model(input logic [40:0] r);
    logic [6:0] addr;
    logic [1:0] op;
    addr = r[40:34];
    op   = r[33:32];
    if (op == OP_RD)
      return (addr == 7'h11) ? {32'hDEADBEEF, 2'b00} : {32'hA5A50000 | {25'h0, addr}, 2'b00};
    if (op == OP_WR && addr == 7'h7F)
      return {32'h0, 2'b11};
    return '0;
  endfunction

  int unsigned dm_lat [2];
  logic        pend   [2];
  logic [7:0]  cnt    [2];
  logic [33:0] rbuf   [2];

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < 2; k++) begin
        pend[k] <= 1'b0;
        cnt[k]  <= '0;
        rbuf[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (d_req_valid[k] && d_req_ready[k]) begin
          pend[k] <= 1'b1;
          cnt[k]  <= 8'(dm_lat[k] - 1);
          rbuf[k] <= dm_model(d_req[k]);
        end else if (pend[k] && cnt[k] != 8'd0) begin
          cnt[k] <= cnt[k] - 8'd1;
        end else if (pend[k] && d_resp_ready[k]) begin
          pend[k] <= 1'b0;
        end
      end
    end
  end

  assign d_req_ready[0]  = !pend[0];
  assign d_req_ready[1]  = !pend[1];
  assign d_resp_valid[0] = pend[0] && (cnt[0] == 8'd0);
  assign d_resp_valid[1] = pend[1] && (cnt[1] == 8'd0);
  assign d_resp[0]       = rbuf[0];
  assign d_resp[1]       = rbuf[1];

  typedef struct packed {
    logic [2:0]  port;
    logic [33:0] resp;
  } exp_t;

  exp_t exp_a[$];
  exp_t exp_b[$];
  int   checks;
  int   errors;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input bit inst, input logic [2:0] port, input logic [31:0] data,
                      input logic [1:0] rc);
    exp_t e;
    e.port = port;
    e.resp = {data, rc};
    if (inst) exp_b.push_back(e);
    else      exp_a.push_back(e);
  endtask

  // Pops the expected response whenever a master response handshake is about to complete.
  task automatic monitor();
    logic [2:0] mi;
    exp_t       e;
    forever begin
      @(negedge clk_i);
      for (int m = 0; m < 5; m++) begin
        mi = 3'(m);
        if (m_resp_valid[mi] && m_resp_ready[mi]) begin
          if (mi < 3'd2) begin
            if (exp_a.size() == 0) begin
              chk("mon_a_unexpected_port", 64'(mi), 64'd7);
            end else begin
              e = exp_a.pop_front();
              chk("mon_a_port", 64'(mi), 64'(e.port));
              chk("mon_a_resp", 64'(m_resp[mi]), 64'(e.resp));
              chk("mon_a_owner", 64'(a_owner), 64'(e.port));
            end
          end else begin
            if (exp_b.size() == 0) begin
              chk("mon_b_unexpected_port", 64'(mi - 3'd2), 64'd7);
            end else begin
              e = exp_b.pop_front();
              chk("mon_b_port", 64'(mi - 3'd2), 64'(e.port));
              chk("mon_b_resp", 64'(m_resp[mi]), 64'(e.resp));
              chk("mon_b_owner", 64'(b_owner), 64'(e.port));
            end
          end
        end
      end
    end
  endtask

  // Called shortly after a rising edge; returns shortly after the accepting edge.
  task automatic send(input logic [2:0] m, input logic [6:0] addr, input logic [1:0] op,
                      input logic [31:0] data);
    int n;
    m_req[m]   = {addr, op, data};
    m_valid[m] = 1'b1;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!m_ready[m] && n < 100);
    chk("send_accepted", 64'(m_ready[m]), 64'd1);
    @(posedge clk_i);
    #1;
    m_valid[m] = 1'b0;
    m_req[m]   = '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0 || a_busy || b_busy) && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    chk("drain_a", 64'(exp_a.size()), 64'd0);
    chk("drain_b", 64'(exp_b.size()), 64'd0);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int n;
    checks       = 0;
    errors       = 0;
    rst_ni       = 1'b0;
    m_req        = '0;
    m_valid      = '0;
    m_resp_ready = '1;
    dm_lat[0]    = 1;
    dm_lat[1]    = 1;
    fork
      monitor();
      begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset with requests pending: everything quiet.
    m_valid = 5'b11111;
    repeat (3) @(negedge clk_i);
    chk("rst_req_ready", 64'(m_ready), 64'd0);
    chk("rst_resp_valid", 64'(m_resp_valid), 64'd0);
    chk("rst_busy_a", 64'(a_busy), 64'd0);
    chk("rst_busy_b", 64'(b_busy), 64'd0);
    chk("rst_owner_a", 64'(a_owner), 64'd0);
    chk("rst_owner_b", 64'(b_owner), 64'd0);
    chk("rst_dmi_req_valid", 64'(d_req_valid[0]), 64'd0);
    chk("rst_dmi_resp_ready", 64'(d_resp_ready[0]), 64'd0);
    m_valid = '0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Single read from port 1, cycle by cycle.
    push(1'b0, 3'd1, 32'hDEADBEEF, 2'b00);
    m_req[1]   = {7'h11, OP_RD, 32'h0};
    m_valid[1] = 1'b1;
    @(negedge clk_i);
    chk("t2_arb_busy", 64'(a_busy), 64'd0);
    chk("t2_arb_no_fwd", 64'(d_req_valid[0]), 64'd0);
    @(negedge clk_i);
    chk("t2_req_valid", 64'(d_req_valid[0]), 64'd1);
    chk("t2_req_addr", 64'(d_req[0][40:34]), 64'h11);
    chk("t2_req_ready", 64'(m_ready[1:0]), 64'b10);
    @(posedge clk_i);
    #1;
    m_valid[1] = 1'b0;
    m_req[1]   = '0;
    @(negedge clk_i);
    chk("t2_resp_valid", 64'(m_resp_valid[1:0]), 64'b10);
    chk("t2_resp_data", 64'(m_resp[1][33:2]), 64'hDEADBEEF);
    chk("t2_resp_other", 64'(m_resp[0]), 64'd0);
    drain();

    // Both ports busy: grants alternate 0,1,0,1.
    push(1'b0, 3'd0, 32'hA5A50001, 2'b00);
    push(1'b0, 3'd1, 32'hA5A50003, 2'b00);
    push(1'b0, 3'd0, 32'h00000000, 2'b11);
    push(1'b0, 3'd1, 32'h00000000, 2'b00);
    fork
      begin
        send(3'd0, 7'h01, OP_RD, 32'h0);
        send(3'd0, 7'h7F, OP_WR, 32'h12345678);
      end
      begin
        send(3'd1, 7'h03, OP_RD, 32'h0);
        send(3'd1, 7'h00, OP_NOP, 32'h0);
      end
    join
    drain();

    // Port 0 stalls its response; port 1 must wait.
    push(1'b0, 3'd0, 32'hA5A50005, 2'b00);
    push(1'b0, 3'd1, 32'hA5A50006, 2'b00);
    m_resp_ready[0] = 1'b0;
    fork
      send(3'd0, 7'h05, OP_RD, 32'h0);
      send(3'd1, 7'h06, OP_RD, 32'h0);
      begin
        n = 0;
        do begin
          @(negedge clk_i);
          n++;
        end while (!m_resp_valid[0] && n < 50);
        chk("t4_resp_seen", 64'(m_resp_valid[1:0]), 64'b01);
        repeat (5) begin
          chk("t4_dmi_resp_ready", 64'(d_resp_ready[0]), 64'd0);
          chk("t4_port1_ready", 64'(m_ready[1]), 64'd0);
          chk("t4_owner", 64'(a_owner), 64'd0);
          @(negedge clk_i);
        end
        @(posedge clk_i);
        #1;
        m_resp_ready[0] = 1'b1;
      end
    join
    chk("t4_owner_after", 64'(a_owner), 64'd1);
    drain();

    // Three ports: pointer at 2 with requests on 0 and 1, then wrap.
    push(1'b1, 3'd1, 32'hA5A50021, 2'b00);
    send(3'd3, 7'h21, OP_RD, 32'h0);
    drain();
    push(1'b1, 3'd0, 32'hA5A50022, 2'b00);
    push(1'b1, 3'd1, 32'hA5A50023, 2'b00);
    fork
      send(3'd2, 7'h22, OP_RD, 32'h0);
      send(3'd3, 7'h23, OP_RD, 32'h0);
      begin
        n = 0;
        do begin
          @(negedge clk_i);
          n++;
        end while (!b_busy && n < 50);
        chk("t5_first_grant", 64'(b_owner), 64'd0);
      end
    join
    drain();
    push(1'b1, 3'd2, 32'hA5A50024, 2'b00);
    send(3'd4, 7'h24, OP_RD, 32'h0);
    chk("t5_owner_2", 64'(b_owner), 64'd2);
    drain();
    push(1'b1, 3'd1, 32'hA5A50025, 2'b00);
    push(1'b1, 3'd2, 32'hA5A50026, 2'b00);
    fork
      send(3'd3, 7'h25, OP_RD, 32'h0);
      send(3'd4, 7'h26, OP_RD, 32'h0);
    join
    chk("t5_owner_last", 64'(b_owner), 64'd2);
    drain();

    // Reset while waiting for a slow DM response.
    dm_lat[0] = 4;
    send(3'd0, 7'h08, OP_RD, 32'h0);
    @(negedge clk_i);
    chk("t6_busy_before", 64'(a_busy), 64'd1);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    #1;
    chk("t6_busy_async", 64'(a_busy), 64'd0);
    @(negedge clk_i);
    chk("t6_busy", 64'(a_busy), 64'd0);
    chk("t6_resp_valid", 64'(m_resp_valid), 64'd0);
    chk("t6_owner", 64'(a_owner), 64'd0);
    @(posedge clk_i);
    #1;
    rst_ni    = 1'b1;
    dm_lat[0] = 1;
    @(posedge clk_i);
    #1;
    push(1'b0, 3'd1, 32'hA5A50009, 2'b00);
    send(3'd1, 7'h09, OP_RD, 32'h0);
    chk("t6_new_owner", 64'(a_owner), 64'd1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
